alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 4, operand/result width; it SHALL match the shared ALU width.
REQ-002 SHALL have parameter OP_W, default 3, opcode width.
REQ-003 SHALL have ports: clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0_valid, req1_valid  input  1 each  requester n has an operation pending.
REQ-006 req0_ready, req1_ready  output  1 each  arbiter accepts requester n this cycle.
REQ-007 req0_opcode, req1_opcode  input  OP_W each  requested ALU opcode.
REQ-008 req0_a, req0_b, req1_a, req1_b  input  DATA_W each  requested operands.
REQ-009 resp0_valid, resp1_valid  output  1 each  result available for requester n.
REQ-010 resp0_ready, resp1_ready  input  1 each  requester n consumes its result.
REQ-011 resp_data  output  DATA_W  result of the completed operation, shared by both responses.
REQ-012 resp_err  output  1  completed operation had an unsupported opcode.
REQ-013 alu_opcode  output  OP_W; alu_op1, alu_op2  output  DATA_W each  registered drive to the shared ALU.
REQ-014 alu_result  input  DATA_W  combinational result from the shared ALU.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 IDLE: reqN_ready = 1 only for the granted requester; all other ready outputs 0.
REQ-017 Grant: only one valid -> that requester; both valid -> the requester not served last (round-robin); none valid -> no grant.
REQ-018 On reqN_valid && reqN_ready: latch opcode/operands into alu_* registers, record owner N, go EXEC.
REQ-019 EXEC (exactly one cycle): capture alu_result into resp_data, go RESP.
REQ-020 Supported opcodes 000 add, 001 sub, 010 and, 011 or; opcodes 100-111 SHALL set resp_err = 1 and resp_data = 0, with the ALU result ignored.
REQ-021 Arithmetic wraps modulo 2^DATA_W; no carry/borrow output.
REQ-022 RESP: respN_valid = 1 for owner only; resp_data/resp_err held stable until respN_ready.
REQ-023 On respN_valid && respN_ready: update last-served pointer to N, go IDLE; ready outputs are 0 in this cycle.
REQ-024 Latency: accept edge -> respN_valid high 2 cycles later; minimum accept-to-accept spacing 3 cycles.
REQ-025 No ready is asserted outside IDLE; a requester's valid dropping while not accepted SHALL have no effect.
REQ-026 resp_ready of the non-owner SHALL be ignored.

Reset
REQ-027 rst sampled high at an edge SHALL force IDLE regardless of state, aborting any in-flight operation with no response.
REQ-028 Reset values: all ready/resp_valid = 0, resp_data = 0, resp_err = 0, alu_opcode/alu_op1/alu_op2 = 0, last-served = requester 1 (so requester 0 wins the first tie).

Verification
REQ-029 Req0 only, opcode 000, a=3, b=1 -> req0_ready in IDLE, resp0_valid 2 cycles after accept, resp_data=4, resp_err=0.
REQ-030 Both valid after reset, req0 sub 3-1, req1 or 3|1 -> req0 served first (resp_data=2), then req1 (resp_data=3); next tie goes to req0.
REQ-031 Req1 add a=4'hF, b=1 -> resp_data=0 (wrap), resp_err=0.
REQ-032 Req0 opcode 101 -> resp_err=1, resp_data=0, FSM returns to IDLE after handshake.
REQ-033 resp0_ready held low 5 cycles -> resp0_valid, resp_data stable throughout, no new request accepted; resp1_ready pulsed meanwhile has no effect.
REQ-034 rst asserted for one cycle during EXEC -> next cycle IDLE, no resp_valid, all outputs at reset values; subsequent request completes normally.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and shared-ALU signals for alu_arbiter.
// The arbiter uses the slave side; requesters and the external ALU sit on the master side.
interface alu_arbiter_if #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3
);
    logic              req0_valid;
    logic              req1_valid;
    logic              req0_ready;
    logic              req1_ready;
    logic [OP_W-1:0]   req0_opcode;
    logic [OP_W-1:0]   req1_opcode;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              resp0_valid;
    logic              resp1_valid;
    logic              resp0_ready;
    logic              resp1_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic [DATA_W-1:0] alu_result;

    modport slave (
        input  req0_valid, req1_valid, req0_opcode, req1_opcode,
        input  req0_a, req0_b, req1_a, req1_b,
        input  resp0_ready, resp1_ready, alu_result,
        output req0_ready, req1_ready, resp0_valid, resp1_valid,
        output resp_data, resp_err, alu_opcode, alu_op1, alu_op2
    );

    modport master (
        output req0_valid, req1_valid, req0_opcode, req1_opcode,
        output req0_a, req0_b, req1_a, req1_b,
        output resp0_ready, resp1_ready, alu_result,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid,
        input  resp_data, resp_err, alu_opcode, alu_op1, alu_op2
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
module alu_arbiter #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    alu_arbiter_if.slave       bus,
    output logic [1:0]         o_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic              r_last;
    logic              r_resp0_valid;
    logic              r_resp1_valid;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;
    logic [OP_W-1:0]   r_alu_opcode;
    logic [DATA_W-1:0] r_alu_op1;
    logic [DATA_W-1:0] r_alu_op2;

    logic w_grant0;
    logic w_grant1;
    logic w_supported;
    logic w_resp_done;

    // Grant is decoded from the current valids so a lone requester is accepted in the same cycle.
    assign w_grant0    = (r_state == IDLE) && bus.req0_valid && (!bus.req1_valid || r_last);
    assign w_grant1    = (r_state == IDLE) && bus.req1_valid && (!bus.req0_valid || !r_last);
    assign w_supported = (r_alu_opcode < OP_W'(4));
    assign w_resp_done = r_owner ? bus.resp1_ready : bus.resp0_ready;

    assign bus.req0_ready  = w_grant0;
    assign bus.req1_ready  = w_grant1;
    assign bus.resp0_valid = r_resp0_valid;
    assign bus.resp1_valid = r_resp1_valid;
    assign bus.resp_data   = r_resp_data;
    assign bus.resp_err    = r_resp_err;
    assign bus.alu_opcode  = r_alu_opcode;
    assign bus.alu_op1     = r_alu_op1;
    assign bus.alu_op2     = r_alu_op2;
    assign o_state         = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_owner       <= 1'b0;
            r_last        <= 1'b1;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp_data   <= '0;
            r_resp_err    <= 1'b0;
            r_alu_opcode  <= '0;
            r_alu_op1     <= '0;
            r_alu_op2     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0) begin
                        r_alu_opcode <= bus.req0_opcode;
                        r_alu_op1    <= bus.req0_a;
                        r_alu_op2    <= bus.req0_b;
                        r_owner      <= 1'b0;
                        r_state      <= EXEC;
                    end else if (w_grant1) begin
                        r_alu_opcode <= bus.req1_opcode;
                        r_alu_op1    <= bus.req1_a;
                        r_alu_op2    <= bus.req1_b;
                        r_owner      <= 1'b1;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    // Unsupported opcodes discard whatever the ALU produced.
                    r_resp_data   <= w_supported ? bus.alu_result : '0;
                    r_resp_err    <= !w_supported;
                    r_resp0_valid <= !r_owner;
                    r_resp1_valid <= r_owner;
                    r_state       <= RESP;
                end
                RESP: begin
                    if (w_resp_done) begin
                        r_resp0_valid <= 1'b0;
                        r_resp1_valid <= 1'b0;
                        r_last        <= r_owner;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
